// File: rtl/ocp_master_arbiter.sv
// Round-robin arbiter sharing one OCP master FSM between NUM_REQ requesters.
// Burst progress is tracked by snooping SCmdAccept, SResp and SRespLast.
module ocp_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_rd,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*10-1:0]         req_burst_length,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            wdata_pop,
    output logic [NUM_REQ-1:0]            rdata_valid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [ADDR_WIDTH-1:0]         address,
    output logic [9:0]                    burst_length,
    output logic                          read_request,
    output logic                          write_request,
    output logic [DATA_WIDTH-1:0]         write_data,
    input  logic [DATA_WIDTH-1:0]         read_data,
    input  logic                          SCmdAccept,
    input  logic [1:0]                    SResp,
    input  logic                          SRespLast
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WR_BURST, RD_BURST, DONE} state_t;

    state_t             state, state_nx;
    logic [IW-1:0]      rr_ptr, gidx, win, scan;
    logic [NUM_REQ-1:0] pending;
    logic [9:0]         beat_cnt, beat_nx, win_raw, win_len;
    logic [WW-1:0]      wd_cnt;
    logic               found, op_wr, end_err, beat, in_burst;
    logic               dva, fail, wd_exp, len_hit;

    assign pending  = req_rd | req_wr;
    assign dva      = (SResp == 2'b01);
    assign fail     = SResp[1];
    assign in_burst = (state == WR_BURST) || (state == RD_BURST);
    assign beat     = ((state == WR_BURST) && SCmdAccept) ||
                      ((state == RD_BURST) && dva);
    assign beat_nx  = beat_cnt + 10'd1;
    assign len_hit  = (beat_nx == burst_length) ||
                      ((state == RD_BURST) && SRespLast);
    assign wd_exp   = (wd_cnt == WW'(TIMEOUT - 1));
    assign win_raw  = req_burst_length[win*10 +: 10];
    assign win_len  = (win_raw == 10'd0) ? 10'd1 : win_raw;

    assign wdata_pop  = ((state == WR_BURST) && SCmdAccept) ? grant : '0;
    assign write_data = (|grant) ? req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

    // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && pending[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end
    end

    always_comb begin
        state_nx = state;
        end_err  = 1'b0;
        unique case (state)
            IDLE:  if (found) state_nx = ISSUE;
            ISSUE: state_nx = op_wr ? WR_BURST : RD_BURST;
            WR_BURST, RD_BURST: begin
                if (fail) begin
                    state_nx = DONE;
                    end_err  = 1'b1;
                end else if (beat) begin
                    if (len_hit) state_nx = DONE;
                end else if (wd_exp) begin
                    state_nx = DONE;
                    end_err  = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gidx          <= '0;
            op_wr         <= 1'b0;
            beat_cnt      <= '0;
            wd_cnt        <= '0;
            grant         <= '0;
            rdata_valid   <= '0;
            rdata         <= '0;
            done          <= '0;
            err           <= '0;
            address       <= '0;
            burst_length  <= '0;
            read_request  <= 1'b0;
            write_request <= 1'b0;
        end else begin
            state         <= state_nx;
            read_request  <= 1'b0;
            write_request <= 1'b0;
            rdata_valid   <= '0;
            done          <= '0;
            err           <= '0;
            if ((state == IDLE) && found) begin
                grant         <= NUM_REQ'(1) << win;
                gidx          <= win;
                address       <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                burst_length  <= win_len;
                op_wr         <= req_wr[win];
                write_request <= req_wr[win];
                read_request  <= !req_wr[win];
                beat_cnt      <= '0;
                wd_cnt        <= '0;
            end
            if (in_burst) begin
                if (beat) begin
                    beat_cnt <= beat_nx;
                    wd_cnt   <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
            if ((state == RD_BURST) && dva) begin
                rdata       <= read_data;
                rdata_valid <= grant;
            end
            if (in_burst && (state_nx == DONE)) begin
                done <= grant;
                err  <= end_err ? grant : '0;
            end
            if (state == DONE) begin
                grant  <= '0;
                rr_ptr <= (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Randomized self-checking bench for ocp_master_arbiter.
// A transaction-level model predicts winner, beats, data and end status.
module tb_ocp_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            sys_clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_rd, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*10-1:0] req_burst_length;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant, wdata_pop, rdata_valid, done, err;
    logic [DW-1:0]   rdata, write_data, read_data;
    logic [AW-1:0]   address;
    logic [9:0]      burst_length;
    logic            read_request, write_request;
    logic            SCmdAccept, SRespLast;
    logic [1:0]      SResp;

    int checks   = 0;
    int failures = 0;
    int exp_rr   = 0;
    logic [7:0] rd_script[$];

    ocp_master_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .sys_clk(sys_clk), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_burst_length(req_burst_length),
        .req_wdata(req_wdata),
        .grant(grant), .wdata_pop(wdata_pop), .rdata_valid(rdata_valid),
        .rdata(rdata), .done(done), .err(err),
        .address(address), .burst_length(burst_length),
        .read_request(read_request), .write_request(write_request),
        .write_data(write_data), .read_data(read_data),
        .SCmdAccept(SCmdAccept), .SResp(SResp), .SRespLast(SRespLast)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic bus_idle();
        SCmdAccept = 1'b0;
        SResp      = 2'b00;
        SRespLast  = 1'b0;
        read_data  = '0;
    endtask

    // Runs one whole transaction; g is the index the DUT actually granted
    task automatic run_txn(input int delay, input bit rnd, input int err_at,
                           input int last_at, input bit stall,
                           output int g, output bit wrop,
                           output int n_pop, output int n_rv);
        logic [N-1:0] pend;
        logic [7:0]   d;
        int  w, len, beats, idle, cyc;
        bit  got, ended, e_err, act, fail_now, last_now, wr;
        pend  = req_rd | req_wr;
        w     = -1;
        n_pop = 0;
        n_rv  = 0;
        g     = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && pend[(exp_rr + k) % N]) w = (exp_rr + k) % N;
        if (w < 0) w = 0;
        wr   = req_wr[w];
        wrop = wr;
        len  = int'(req_burst_length[w*10 +: 10]);
        if (len == 0) len = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (grant != '0) got = 1'b1;
        end
        chk("grant_seen", 64'(got), 64'(1));
        if (!got) return;
        for (int i = 0; i < N; i++) if (grant[i]) g = i;
        chk("grant", 64'(grant), 64'(oh(w)));
        chk("address", address, req_addr[w*AW +: AW]);
        chk("burst_len", 64'(burst_length), 64'(len));
        chk("wr_req", 64'(write_request), 64'(wr));
        chk("rd_req", 64'(read_request), 64'(!wr));
        chk("issue_pop", 64'(wdata_pop), 64'(0));
        bus_idle();
        tick();
        chk("req_pulse", 64'({read_request, write_request}), 64'(0));
        beats = 0;
        idle  = 0;
        cyc   = 0;
        ended = 1'b0;
        e_err = 1'b0;
        while (!ended && cyc < 4000) begin
            cyc++;
            fail_now = !stall && err_at >= 0 && beats == err_at && cyc > delay;
            act      = !stall && !fail_now && cyc > delay &&
                       (!rnd || $urandom_range(1, 0) == 1);
            last_now = act && !wr && (beats + 1 == last_at);
            d = 8'($urandom);
            if (act && !wr && rd_script.size() > 0) d = rd_script.pop_front();
            SCmdAccept = wr && act;
            SResp      = fail_now ? ($urandom_range(1, 0) ? 2'b11 : 2'b10)
                       : (!wr && act) ? 2'b01 : 2'b00;
            SRespLast  = last_now;
            read_data  = d;
            #1;
            chk("pop", 64'(wdata_pop), 64'((wr && act) ? oh(w) : '0));
            if (wr) chk("wdata", 64'(write_data), 64'(req_wdata[w*DW +: DW]));
            if (wr && act) n_pop++;
            if (fail_now) begin
                ended = 1'b1;
                e_err = 1'b1;
            end else if (act) begin
                beats++;
                idle = 0;
                if (beats == len || last_now) ended = 1'b1;
            end else begin
                idle++;
                if (idle == TO) begin
                    ended = 1'b1;
                    e_err = 1'b1;
                end
            end
            tick();
            if (wr && act) req_wdata[w*DW +: DW] = 8'($urandom);
            chk("rvalid", 64'(rdata_valid), 64'((!wr && act) ? oh(w) : '0));
            if (!wr && act) begin
                n_rv++;
                chk("rdata", 64'(rdata), 64'(d));
            end
            chk("done", 64'(done), 64'(ended ? oh(w) : '0));
            chk("err", 64'(err), 64'((ended && e_err) ? oh(w) : '0));
        end
        chk("burst_end", 64'(ended), 64'(1));
        bus_idle();
        exp_rr = (w + 1) % N;
        tick();
        chk("grant_clr", 64'(grant), 64'(0));
        chk("done_clr", 64'(done), 64'(0));
    endtask

    initial begin
        int g, np, nr;
        bit wo;
        logic [15:0] seq;
        bit got;
        reset            = 1'b1;
        req_rd           = '0;
        req_wr           = '0;
        req_addr         = '0;
        req_burst_length = '0;
        req_wdata        = '0;
        bus_idle();
        repeat (3) tick();
        chk("rst_state", 64'({grant, wdata_pop, rdata_valid, done, err,
            read_request, write_request, write_data, rdata, burst_length}),
            64'(0));
        chk("rst_addr", address, 64'(0));
        reset = 1'b0;

        // single write to the top of the address space
        req_addr[0*AW +: AW]         = '1;
        req_burst_length[0*10 +: 10] = 10'd1;
        req_wdata[0*DW +: DW]        = 8'hFF;
        req_wr = 4'b0001;
        run_txn(2, 1'b0, -1, -1, 1'b0, g, wo, np, nr);
        chk("t1_g", 64'(g), 64'(0));
        chk("t1_pops", 64'(np), 64'(1));
        req_wr = '0;

        // read burst with SRespLast on the final beat
        req_addr[1*AW +: AW]         = '0;
        req_burst_length[1*10 +: 10] = 10'd4;
        rd_script = '{8'h04, 8'h08, 8'h0C, 8'h20};
        req_rd = 4'b0010;
        run_txn(0, 1'b0, -1, 4, 1'b0, g, wo, np, nr);
        chk("t2_g", 64'(g), 64'(1));
        chk("t2_beats", 64'(nr), 64'(4));
        req_rd = '0;

        // requester 3 wraps the pointer back to 0
        req_burst_length[3*10 +: 10] = 10'd1;
        req_wr = 4'b1000;
        run_txn(0, 1'b0, -1, -1, 1'b0, g, wo, np, nr);
        chk("wrap_g", 64'(g), 64'(3));
        req_wr = '0;

        // round robin between two held requesters
        req_burst_length[0*10 +: 10] = 10'd1;
        req_burst_length[2*10 +: 10] = 10'd1;
        req_wr = 4'b0101;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            run_txn(0, 1'b1, -1, -1, 1'b0, g, wo, np, nr);
            seq = {seq[11:0], 4'(g)};
        end
        chk("rr_seq", 64'(seq), 64'(16'h0202));
        req_wr = '0;

        // early SRespLast
        req_burst_length[1*10 +: 10] = 10'd4;
        req_rd = 4'b0010;
        run_txn(0, 1'b0, -1, 2, 1'b0, g, wo, np, nr);
        chk("early_beats", 64'(nr), 64'(2));
        req_rd = '0;

        // error response on the first beat
        req_burst_length[2*10 +: 10] = 10'd3;
        req_rd = 4'b0100;
        run_txn(0, 1'b0, 0, -1, 1'b0, g, wo, np, nr);
        chk("errresp_beats", 64'(nr), 64'(0));
        req_rd = '0;

        // watchdog: write never accepted
        req_burst_length[1*10 +: 10] = 10'd2;
        req_wr = 4'b0010;
        run_txn(0, 1'b0, -1, -1, 1'b1, g, wo, np, nr);
        chk("timeout_pops", 64'(np), 64'(0));
        req_wr = '0;

        // async reset in the middle of a write burst
        req_burst_length[3*10 +: 10] = 10'd4;
        req_wr = 4'b1000;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (grant != '0) got = 1'b1;
        end
        chk("rst_grant", 64'(grant), 64'(oh(3)));
        tick();
        SCmdAccept = 1'b1;
        tick();
        #1;
        chk("rst_pop", 64'(wdata_pop), 64'(oh(3)));
        reset = 1'b1;
        #1;
        chk("rst_mid", 64'({grant, wdata_pop, rdata_valid, done, err,
            read_request, write_request, write_data, rdata, burst_length}),
            64'(0));
        chk("rst_mid_addr", address, 64'(0));
        bus_idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_nodone", 64'(done), 64'(0));
        end
        reset  = 1'b0;
        exp_rr = 0;
        req_burst_length[1*10 +: 10] = 10'd1;
        req_wr = 4'b1010;
        run_txn(0, 1'b1, -1, -1, 1'b0, g, wo, np, nr);
        chk("post_rst_g", 64'(g), 64'(1));
        req_wr = 4'b1000;
        run_txn(0, 1'b1, -1, -1, 1'b0, g, wo, np, nr);
        chk("post_rst_g3", 64'(g), 64'(3));
        req_wr = '0;

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int ea, la;
            bit st;
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]         = {$urandom, $urandom};
                req_burst_length[i*10 +: 10] = 10'($urandom_range(6, 0));
                req_wdata[i*DW +: DW]        = 8'($urandom);
                if ($urandom_range(2, 0) == 0) req_wr[i] = 1'b1;
                if ($urandom_range(2, 0) == 0) req_rd[i] = 1'b1;
            end
            if ((req_rd | req_wr) == '0) req_wr[$urandom_range(N - 1, 0)] = 1'b1;
            ea = ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
            la = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : -1;
            st = ($urandom_range(19, 0) == 0);
            run_txn(int'($urandom_range(2, 0)), 1'b1, ea, la, st, g, wo, np, nr);
            if (g >= 0 && g < N && $urandom_range(3, 0) != 0) begin
                if (wo) req_wr[g] = 1'b0;
                else    req_rd[g] = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ocp_master_arbiter.md
Name: ocp_master_arbiter

Overview:
- Shares the single OCP master FSM between NUM_REQ bridge-side requesters, e.g. PCIe completion and DMA engines.
- Arbitrates round-robin and drives the master FSM's bridge interface: address, burst_length, read_request, write_request, write_data.
- Tracks burst completion by snooping the OCP handshake (SCmdAccept, SResp, SRespLast).
- Returns read data, write-data pops and done/error status to the granted requester.

Parameters:
NUM_REQ, 4, number of requesters; 2..8
ADDR_WIDTH, 64, address width; matches MADDR_WIDTH
DATA_WIDTH, 8, data width; matches MDATA_WIDTH
TIMEOUT, 1024, watchdog cycles without beat progress before abort

Ports:
sys_clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
req_rd  in  NUM_REQ  level read request, one bit per requester
req_wr  in  NUM_REQ  level write request, one bit per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_burst_length  in  NUM_REQ*10  packed burst lengths in beats
req_wdata  in  NUM_REQ*DATA_WIDTH  packed current write beat per requester
grant  out  NUM_REQ  one-hot; held for the whole transaction
wdata_pop  out  NUM_REQ  1-cycle pulse: granted requester's write beat consumed, present the next one
rdata_valid  out  NUM_REQ  1-cycle pulse: rdata holds a beat for that requester
rdata  out  DATA_WIDTH  read beat, shared by all requesters
done  out  NUM_REQ  1-cycle pulse at transaction end
err  out  NUM_REQ  1-cycle pulse with done on FAIL/ERR response or timeout
address  out  ADDR_WIDTH  to master FSM
burst_length  out  10  to master FSM
read_request  out  1  to master FSM; 1-cycle pulse
write_request  out  1  to master FSM; 1-cycle pulse
write_data  out  DATA_WIDTH  to master FSM; muxed from granted requester's req_wdata
read_data  in  DATA_WIDTH  from master FSM
SCmdAccept  in  1  snooped OCP command accept
SResp  in  2  snooped OCP response; NULL=00, DVA=01, FAIL=10, ERR=11
SRespLast  in  1  snooped OCP last-response flag

Behaviour:
- Reset: async assert clears everything, mid-transaction included.
  - All outputs 0; grant 0; state IDLE; rr_ptr 0; beat and watchdog counters 0.
  - No done is issued for an aborted transaction.
- States: IDLE, ISSUE, WR_BURST, RD_BURST, DONE.
- IDLE:
  - Pending for requester i = req_rd[i] | req_wr[i].
  - Winner = first pending index scanning rr_ptr, rr_ptr+1, … with modulo NUM_REQ wrap.
  - On a winner: register grant, address, burst_length and op; go to ISSUE next cycle.
  - Burst length 0 is treated as 1.
  - req_wr and req_rd both set on one requester: write is performed; the read stays pending for a later grant.
- ISSUE: read_request or write_request high for exactly this one cycle; next state is WR_BURST or RD_BURST.
- WR_BURST:
  - Each cycle with SCmdAccept=1 counts one beat and pulses wdata_pop[g] in that cycle.
  - write_data = req_wdata[g] combinationally.
  - When beat count reaches burst_length, go to DONE.
- RD_BURST:
  - Each cycle with SResp=DVA: rdata <= read_data, pulse rdata_valid[g] one cycle later (1-cycle registered latency), count one beat.
  - Terminate to DONE when count == burst_length, or on DVA with SRespLast=1, whichever comes first.
  - SResp=NULL is ignored.
- Errors: SResp FAIL or ERR in either burst state ends the transaction; err[g] is pulsed together with done[g].
- Watchdog:
  - Counter resets on every counted beat; it counts only in WR_BURST and RD_BURST.
  - Reaching TIMEOUT goes to DONE with err.
- DONE:
  - done[g] pulses this one cycle.
  - rr_ptr <= (g+1) mod NUM_REQ; grant cleared; back to IDLE.
  - Minimum idle gap between transactions is 1 cycle; the next arbitration happens in IDLE.
- Requests are level-sensitive. A requester still asserting after done is re-arbitrated behind the others.
- Changes on ungranted request lines during a transaction are ignored.
- Outputs registered except write_data. address and burst_length hold their registered values until the next grant.

Test Plan:
1. Single write: req_wr[0]=1, addr=64'hFFFF_FFFF_FFFF_FFFF, len=1, SCmdAccept asserted 2 cycles after write_request → write_request pulses 1 cycle, write_data=8'hFF, one wdata_pop[0], done[0] pulse, grant returns 0.
2. Read burst: req_rd[1], addr=0, len=4, DVA beats 04,08,0C,20 with SRespLast on the 4th → rdata_valid[1] pulses 4 times with matching rdata, done[1] after the 4th beat, err=0.
3. Round-robin: req_wr[0] and req_wr[2] held continuously, len=1 → grant sequence 0,2,0,2; rr_ptr wraps 3→0 correctly when NUM_REQ=4.
4. Early last: read len=4 with SRespLast on the 2nd DVA beat → exactly 2 rdata_valid pulses, done after the 2nd beat.
5. Error/timeout: SResp=ERR on beat 1 → done and err pulse together. Separately, SCmdAccept held 0 for TIMEOUT=16 cycles → err after 16 cycles.
6. Reset mid-burst: async reset during beat 2 of a write burst with len=4 → all outputs 0 immediately; no done. After release, the pending request is re-granted starting from requester 0.
